// File: rtl/dmem_responder_if.sv
// Processor data-memory bus between a requesting master and a responding slave.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, adr, wdata,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, adr, wdata,
        output ready, ack, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with fixed wait states, bounds/alignment
// fault reporting and an observation port for committed writes.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned VIEW        = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_responder_if.slave       bus,
    output logic                  wstrobe,
    output logic [31:0]           obs_adr,
    output logic [31:0]           obs_data,
    output logic [VIEW-1:0][31:0] mem_view
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic          enter_resp;

    logic          cap_we;
    logic [31:0]   cap_adr;
    logic [31:0]   cap_wdata;

    logic          c_we;
    logic [31:0]   c_adr;
    logic [31:0]   c_wdata;
    logic          c_legal;
    logic [AW-1:0] c_idx;
    logic          commit;

    logic          in_resp;
    logic          rsp_legal;
    logic [AW-1:0] rsp_idx;

    logic [31:0]   mem [DEPTH];

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DEPTH));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_adr   <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_we    <= bus.we;
            cap_adr   <= bus.adr;
            cap_wdata <= bus.wdata;
        end
    end

    // With no wait states the commit edge is the accept edge, so the live bus
    // fields stand in for the not-yet-captured ones.
    always_comb begin
        c_we    = cap_we;
        c_adr   = cap_adr;
        c_wdata = cap_wdata;
        if (state_q == S_IDLE) begin
            c_we    = bus.we;
            c_adr   = bus.adr;
            c_wdata = bus.wdata;
        end
        c_legal = is_legal(c_adr);
        c_idx   = c_adr[AW+1:2];
        commit  = enter_resp && c_we && c_legal && reset;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obs_adr  <= '0;
            obs_data <= '0;
        end else if (commit) begin
            obs_adr  <= c_adr;
            obs_data <= c_wdata;
        end
    end

    always_comb begin
        in_resp   = (state_q == S_RESP);
        rsp_legal = is_legal(cap_adr);
        rsp_idx   = cap_adr[AW+1:2];
        bus.ready = (state_q == S_IDLE);
        bus.ack   = in_resp;
        bus.err   = in_resp && !rsp_legal;
        wstrobe   = in_resp && rsp_legal && cap_we;
        bus.rdata = '0;
        if (in_resp && rsp_legal && !cap_we) begin
            bus.rdata = mem[rsp_idx];
        end
    end

    for (genvar g = 0; g < VIEW; g++) begin : g_view
        if (g < DEPTH) begin : g_word
            assign mem_view[g] = mem[g];
        end else begin : g_none
            assign mem_view[g] = '0;
        end
    end
endmodule
